mmu_bank: RTL
=============

# mmu_bank

Clocked, parametrised memory-bus decoder that sits between the CPU data port and `NDEV` memory-mapped devices (RAM, VGA, future peripherals). It is the successor of the combinational two-way RAM/VGA split: it decodes a device index from address bits, runs a per-access ready/wait handshake with the selected device, and aborts with a fault on unaligned, unmapped, conflicting or timed-out accesses. It completes exactly one device access per CPU request.

## Interface
Parameters:
- `NDEV`, 4: number of device slots; power of two, ≥2.
- `DEV_ADDR_BITS`, 16: per-device address width; `DEV_ADDR_BITS + log2(NDEV)` ≤ 32.
- `WIDTH`, 32: data width.
- `TIMEOUT`, 8: maximum strobe cycles before a timeout fault; ≥1.

Ports:
- `CLK`  in  1  clock; all state changes on its rising edge.
- `N_RST`  in  1  reset, asynchronous, active-low.
- `ADDR`  in  32  CPU byte address.
- `N_WE`  in  1  CPU write request, active-low, level.
- `N_OE`  in  1  CPU read request, active-low, level.
- `IN`  in  WIDTH  CPU write data.
- `OUT`  out  WIDTH  read data, registered.
- `DONE`  out  1  one-cycle completion pulse, including faulted accesses.
- `FAULT`  out  1  last access faulted.
- `FAULT_CODE`  out  2  0 = conflicting strobes, 1 = unaligned, 2 = unmapped, 3 = timeout.
- `DEV_ADDR`  out  DEV_ADDR_BITS  latched `ADDR[DEV_ADDR_BITS-1:0]`.
- `DEV_IN`  out  WIDTH  latched write data, broadcast to all devices.
- `DEV_N_WE`  out  NDEV  per-device write strobe, active-low.
- `DEV_N_OE`  out  NDEV  per-device read strobe, active-low.
- `DEV_OUT`  in  NDEV*WIDTH  device read data; slot i is at `[i*WIDTH +: WIDTH]`.
- `DEV_RDY`  in  NDEV  per-device ready, sampled only for the selected slot.

## Operation
- Device select: `sel = ADDR[DEV_ADDR_BITS +: log2(NDEV)]`.
- Mapped access: all `ADDR` bits above the select field are 0.
- FSM states are IDLE, ACCESS and HOLD.
- **IDLE:**
  - A request is `!N_WE || !N_OE`. It is sampled at a rising edge.
  - On a request, latch `sel`, `DEV_ADDR`, `DEV_IN` and the direction. Clear `FAULT` and `FAULT_CODE`.
  - Fault checks, highest priority first:
    - both `N_WE` and `N_OE` low → code 0;
    - `ADDR[1:0] != 0` → code 1;
    - unmapped → code 2.
  - On a fault: no strobe; on the same edge set `FAULT=1`, `FAULT_CODE`, `DONE=1`, and `OUT=0` if the access was a read (on a conflict, `OUT=0`). Go to HOLD.
  - Otherwise: drive `DEV_N_WE[sel]` or `DEV_N_OE[sel]` low (registered). Clear the timer. Go to ACCESS.
- **ACCESS:**
  - The strobe is held low; at most one strobe bit is ever low.
  - If `DEV_RDY[sel]` is sampled high at an edge: deassert the strobe, capture `DEV_OUT` slice `sel` into `OUT` if reading, pulse `DONE`, go to HOLD.
  - Else if the timer equals `TIMEOUT-1`: deassert the strobe, `FAULT=1`, code 3, `OUT=0` if reading, `DONE=1`, go to HOLD.
  - Else increment the timer.
  - If RDY and timeout coincide, RDY wins.
- **HOLD:** Go to IDLE at the first edge where `N_WE && N_OE`. A request still held after `DONE` is never re-issued.
- Writes leave `OUT` unchanged.
- `FAULT` and `FAULT_CODE` hold until the next accepted request.
- `ADDR`, `IN` and `DEV_OUT` of unselected slots are ignored outside the IDLE sampling edge.
- Timer width is `$clog2(TIMEOUT+1)`. It never wraps.

## Timing
- Reset values, applied asynchronously:
  - state IDLE;
  - `DEV_N_WE` and `DEV_N_OE` all 1;
  - `OUT`, `DONE`, `FAULT`, `FAULT_CODE`, `DEV_ADDR`, `DEV_IN`, timer all 0.
- Reset asserted mid-ACCESS releases the strobe immediately. No `DONE` is produced.
- The request is sampled at edge E0. The strobe is low from E0.
- The earliest completion is `DONE` high for the cycle after E1, given RDY high before E1. The strobe is low for exactly one cycle.
- A device ready after k cycles (RDY first sampled at edge Ek) holds the strobe low for k cycles. `DONE` follows Ek.
- A timeout holds the strobe low for exactly `TIMEOUT` cycles.
- A fault detected in IDLE raises `DONE` and `FAULT` right after E0; no strobe is issued.
- `DONE` is never high for two consecutive cycles.
- Minimum request-to-request spacing is 3 edges: accept, complete, release.

## Test plan
Defaults: NDEV=4, DEV_ADDR_BITS=16, WIDTH=32, TIMEOUT=8.
- Read at `0x0001_0004`, slot 1 data `0xDEADBEEF`, `DEV_RDY[1]` high → `DEV_N_OE=4'b1101` for 1 cycle, `DEV_ADDR=0x0004`, `DONE` after E1, `OUT=0xDEADBEEF`, `FAULT=0`.
- Write `0x12345678` to `0x0002_0010`, `DEV_RDY[2]` rises after 3 cycles → `DEV_N_WE=4'b1011` for 3 cycles, `DEV_IN=0x12345678`, one `DONE`, `OUT` unchanged.
- Read at `0x0000_0002` → no strobe, `DONE=1`, `FAULT=1`, code 1, `OUT=0`. Read at `0x0004_0000` → code 2. Both `N_WE` and `N_OE` low → code 0.
- Read at `0x0003_0000` with RDY never asserted → `DEV_N_OE[3]` low exactly 8 cycles, then `FAULT=1`, code 3, `OUT=0`, one `DONE`.
- `N_OE` held low 10 cycles after `DONE` → exactly one strobe pulse. Release then re-request → the second access proceeds and `FAULT` clears.
- `N_RST` pulsed low in cycle 2 of a slot-0 access → `DEV_N_OE[0]` high with no clock edge, all outputs at reset values, no `DONE`.

Source files
------------

// File: rtl/mmu_bank_if.sv
// mmu_bank_if: CPU-side and device-side bus bundle for mmu_bank.
//   CPU side   : ADDR, N_WE, N_OE, IN -> bank ; OUT, DONE, FAULT, FAULT_CODE <- bank
//   Device side: DEV_ADDR, DEV_IN, DEV_N_WE, DEV_N_OE <- bank ; DEV_OUT, DEV_RDY -> bank
// modport slave  : the bank itself.
// modport master : the CPU plus device environment driving the bank.
interface mmu_bank_if #(
  parameter int NDEV          = 4,
  parameter int DEV_ADDR_BITS = 16,
  parameter int WIDTH         = 32
);
  logic [31:0]              ADDR;
  logic                     N_WE;
  logic                     N_OE;
  logic [WIDTH-1:0]         IN;
  logic [WIDTH-1:0]         OUT;
  logic                     DONE;
  logic                     FAULT;
  logic [1:0]               FAULT_CODE;
  logic [DEV_ADDR_BITS-1:0] DEV_ADDR;
  logic [WIDTH-1:0]         DEV_IN;
  logic [NDEV-1:0]          DEV_N_WE;
  logic [NDEV-1:0]          DEV_N_OE;
  logic [NDEV*WIDTH-1:0]    DEV_OUT;
  logic [NDEV-1:0]          DEV_RDY;

  modport slave (
    input  ADDR, N_WE, N_OE, IN, DEV_OUT, DEV_RDY,
    output OUT, DONE, FAULT, FAULT_CODE, DEV_ADDR, DEV_IN, DEV_N_WE, DEV_N_OE
  );

  modport master (
    output ADDR, N_WE, N_OE, IN, DEV_OUT, DEV_RDY,
    input  OUT, DONE, FAULT, FAULT_CODE, DEV_ADDR, DEV_IN, DEV_N_WE, DEV_N_OE
  );
endinterface

// File: rtl/mmu_bank.sv
// mmu_bank: clocked memory-bus decoder between the CPU data port and NDEV
// memory-mapped devices. Decodes a slot from ADDR[DEV_ADDR_BITS +: log2(NDEV)],
// runs a strobe/ready handshake with that slot and reports exactly one DONE per
// CPU request, with FAULT/FAULT_CODE on conflict (0), unaligned (1),
// unmapped (2) or timeout (3).
// Ports:
//   CLK   : clock, rising edge
//   N_RST : asynchronous active-low reset
//   bus   : mmu_bank_if.slave carrying the CPU and device bus signals
module mmu_bank #(
  parameter int NDEV          = 4,
  parameter int DEV_ADDR_BITS = 16,
  parameter int WIDTH         = 32,
  parameter int TIMEOUT       = 8
) (
  input logic        CLK,
  input logic        N_RST,
  mmu_bank_if.slave  bus
);

  localparam int SELW     = $clog2(NDEV);
  localparam int MAP_BITS = DEV_ADDR_BITS + SELW;
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_e;

  state_e                   state_q, state_d;
  logic [SELW-1:0]          sel_q, sel_d;
  logic [DEV_ADDR_BITS-1:0] dev_addr_q, dev_addr_d;
  logic [WIDTH-1:0]         dev_in_q, dev_in_d;
  logic                     rd_q, rd_d;
  logic [NDEV-1:0]          dev_n_we_q, dev_n_we_d;
  logic [NDEV-1:0]          dev_n_oe_q, dev_n_oe_d;
  logic [WIDTH-1:0]         out_q, out_d;
  logic                     done_q, done_d;
  logic                     fault_q, fault_d;
  logic [1:0]               fault_code_q, fault_code_d;
  logic [TW-1:0]            timer_q, timer_d;

  logic             req;
  logic             conflict, unaligned, unmapped, fault_in;
  logic [1:0]       code_in;
  logic [SELW-1:0]  sel_in;
  logic             rdy_sel;
  logic             timer_last;
  logic [WIDTH-1:0] dev_rd_data;

  assign req       = !bus.N_WE || !bus.N_OE;
  assign sel_in    = bus.ADDR[DEV_ADDR_BITS +: SELW];
  assign conflict  = !bus.N_WE && !bus.N_OE;
  assign unaligned = bus.ADDR[1:0] != 2'b00;
  // A shift by 32 (full address decoded) yields 0, i.e. always mapped.
  assign unmapped  = (bus.ADDR >> MAP_BITS) != 32'd0;
  assign fault_in  = conflict || unaligned || unmapped;
  assign code_in   = conflict ? 2'd0 : (unaligned ? 2'd1 : 2'd2);

  assign rdy_sel     = bus.DEV_RDY[sel_q];
  assign timer_last  = timer_q == T_LAST;
  assign dev_rd_data = bus.DEV_OUT[sel_q*WIDTH +: WIDTH];

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      dev_addr_q   <= '0;
      dev_in_q     <= '0;
      rd_q         <= 1'b0;
      dev_n_we_q   <= '1;
      dev_n_oe_q   <= '1;
      out_q        <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dev_addr_q   <= dev_addr_d;
      dev_in_q     <= dev_in_d;
      rd_q         <= rd_d;
      dev_n_we_q   <= dev_n_we_d;
      dev_n_oe_q   <= dev_n_oe_d;
      out_q        <= out_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = fault_in ? HOLD : ACCESS;
      ACCESS:  if (rdy_sel || timer_last) state_d = HOLD;
      // Wait for the CPU to drop its request so a held request is not re-issued.
      HOLD:    if (bus.N_WE && bus.N_OE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d        = sel_q;
    dev_addr_d   = dev_addr_q;
    dev_in_d     = dev_in_q;
    rd_d         = rd_q;
    dev_n_we_d   = dev_n_we_q;
    dev_n_oe_d   = dev_n_oe_q;
    out_d        = out_q;
    done_d       = 1'b0;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    timer_d      = timer_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          sel_d        = sel_in;
          dev_addr_d   = bus.ADDR[DEV_ADDR_BITS-1:0];
          dev_in_d     = bus.IN;
          rd_d         = !bus.N_OE;
          fault_d      = 1'b0;
          fault_code_d = '0;
          if (fault_in) begin
            fault_d      = 1'b1;
            fault_code_d = code_in;
            done_d       = 1'b1;
            // Conflicts also have N_OE low, so they clear OUT as a read would.
            if (!bus.N_OE) out_d = '0;
          end else begin
            if (!bus.N_OE) dev_n_oe_d[sel_in] = 1'b0;
            else           dev_n_we_d[sel_in] = 1'b0;
            timer_d = '0;
          end
        end
      end
      ACCESS: begin
        if (rdy_sel) begin
          dev_n_we_d = '1;
          dev_n_oe_d = '1;
          if (rd_q) out_d = dev_rd_data;
          done_d = 1'b1;
        end else if (timer_last) begin
          dev_n_we_d   = '1;
          dev_n_oe_d   = '1;
          fault_d      = 1'b1;
          fault_code_d = 2'd3;
          if (rd_q) out_d = '0;
          done_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD:    ;
      default: ;
    endcase
  end

  assign bus.OUT        = out_q;
  assign bus.DONE       = done_q;
  assign bus.FAULT      = fault_q;
  assign bus.FAULT_CODE = fault_code_q;
  assign bus.DEV_ADDR   = dev_addr_q;
  assign bus.DEV_IN     = dev_in_q;
  assign bus.DEV_N_WE   = dev_n_we_q;
  assign bus.DEV_N_OE   = dev_n_oe_q;

endmodule
